rsc_encoder_par: RTL and testbench
==================================

Name: rsc_encoder_par

Overview:
- Parametrised LTE constituent encoder (RSC, g0=1+D^2+D^3, g1=1+D+D^3) that consumes LANES bits per clock instead of one.
- Sits inside the coder stack behind the block-size/data write-request interface; one instance encodes the natural-order stream, a second encodes the interleaved stream.
- Adds size validation, gapped input, a done pulse, and optional trellis termination.

Parameters:
- LANES, 1, bits accepted per clock; legal values 1, 2, 4, 8.
- SIZE_W, 16, width of the block-size input.
- MAX_K, 6144, largest legal block size in bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- wreq_size  in  1  block-size write strobe
- tb_size_in  in  SIZE_W  block size K in bits, sampled when wreq_size=1
- wreq_data  in  1  data write strobe; LANES bits are taken when wreq_data & ready
- data_in  in  LANES  input bits; bit 0 is earliest in time
- ready  out  1  encoder is accepting data bits
- out_valid  out  1  xk_out/zk_out hold valid systematic/parity bits
- xk_out  out  LANES  systematic bits, same lane order as data_in
- zk_out  out  LANES  parity bits
- tail_valid  out  1  lane 0 of xk_out/zk_out carries a tail bit
- done  out  1  one-cycle pulse at end of block
- err  out  1  one-cycle pulse on an illegal size request

Behaviour:
- Reset state: all outputs 0, state IDLE, d1=d2=d3=0, count=0.
- Per-bit recursion, applied in lane order within one cycle:
  - a = u^d2^d3; x = u; z = a^d1^d3.
  - Then d3<=d2, d2<=d1, d1<=a.
  - Registers hold the state after the last lane.
- FSM:
  - IDLE:
    - Accept wreq_size when 0 < K <= MAX_K and K % LANES == 0: latch K, clear d1..d3 and count, go to ARMED.
    - On an illegal K: pulse err and stay in IDLE.
  - ARMED:
    - ready=1.
    - Each accepted beat adds LANES to count.
    - wreq_data=0 beats are gaps: no state change, out_valid=0.
    - The beat that brings count to K goes to TAIL if the feature is enabled, otherwise to DONE.
  - TAIL: 3 cycles; ready=0 (feature only).
  - DONE: one cycle; done=1, ready=0; then IDLE.
- Latency: outputs are registered and appear exactly 1 cycle after the accepting beat. out_valid mirrors accepted beats, delayed by 1 cycle.
- ready drops combinationally in the cycle after the final beat is accepted. Data beats arriving while ready=0 are dropped.
- wreq_size outside IDLE is ignored: K is not changed and err is not raised.
- wreq_size and wreq_data in the same IDLE cycle: the size is taken, the data beat is dropped.
- Count width is SIZE_W+1; no wrap, since K <= MAX_K.
- Sync reset in any state aborts the block:
  - Next cycle is IDLE with all outputs 0.
  - No done pulse.
  - A pending partial block is discarded.

Optional Feature:
- Macro: RSC_TAIL_TERM_EN.
- Defined: after the last data beat the FSM enters TAIL for 3 cycles.
  - Each cycle: u = d2^d3 (forces a=0), then the recursion above.
  - Lane 0 outputs: xk_out[0]=u, zk_out[0]=d1^d3. Other lanes are 0.
  - tail_valid=1 and out_valid=0 in these cycles.
  - Encoder state is 0 at DONE.
  - done arrives 4 cycles after the output of the final data beat.
- Undefined: the TAIL state is not present and tail_valid is tied 0.
  - Final data beat goes straight to DONE; done arrives 1 cycle after the final output.
  - State is left unterminated.

Test Plan:
- LANES=1, K=40, all-zero data: all xk/zk = 0, 3 tail cycles with xk=zk=0, done=1 exactly once, ready=0 after the 40th beat.
- LANES=1, K=40, data = 1 then 39 zeros: zk_out for the first five bits = 1,1,1,1,0; xk = data; tail leaves d1..d3 = 0 at done.
- LANES=4, K=40, random data: concatenated xk/zk (lane 0 first) bit-identical to the LANES=1 run on the same stream, including tail bits.
- LANES=4:
  - size 6 -> err pulse, stays IDLE.
  - size 0 -> err pulse.
  - size 6148 -> err pulse.
  - size 8 -> accepted with no err.
- Gapped input, wreq_data toggling every other cycle, K=16: outputs equal the ungapped run; out_valid is 0 on gap cycles.
- reset asserted mid-ARMED after 10 beats: next cycle is IDLE, outputs 0, no done. A fresh K=16 block then encodes identically to a block started from power-on.

Source files
------------

// File: rtl/rsc_encoder_par.sv
// rsc_encoder_par: LANES-wide LTE RSC constituent encoder (g0=1+D^2+D^3, g1=1+D+D^3).
// Define RSC_TAIL_TERM_EN to append 3 trellis-termination cycles after every block.
module rsc_encoder_par #(
  parameter int LANES  = 1,
  parameter int SIZE_W = 16,
  parameter int MAX_K  = 6144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wreq_size,
  input  logic [SIZE_W-1:0] tb_size_in,
  input  logic              wreq_data,
  input  logic [LANES-1:0]  data_in,
  output logic              ready,
  output logic              out_valid,
  output logic [LANES-1:0]  xk_out,
  output logic [LANES-1:0]  zk_out,
  output logic              tail_valid,
  output logic              done,
  output logic              err
);
  localparam int CNT_W = SIZE_W + 1;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] MAX_K_C = CNT_W'(MAX_K);

`ifdef RSC_TAIL_TERM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_TAIL = 2'd2, ST_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_DONE = 2'd3} state_t;
`endif

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r, k_r, count_nxt_s, size_ext_s;
  logic [2:0]       d_r, enc_d_s;
  logic [LANES-1:0] enc_x_s, enc_z_s, xk_r, zk_r;
  logic             d1_s, d2_s, d3_s, a_s;
  logic             size_ok_s, size_acc_s, size_bad_s, beat_s, last_s;
  logic             out_valid_r, done_r, err_r;

  assign size_ext_s  = {1'b0, tb_size_in};
  assign size_ok_s   = (size_ext_s != {CNT_W{1'b0}}) && (size_ext_s <= MAX_K_C) &&
                       ((size_ext_s % LANES_C) == {CNT_W{1'b0}});
  assign size_acc_s  = (state_r == ST_IDLE) && wreq_size && size_ok_s;
  assign size_bad_s  = (state_r == ST_IDLE) && wreq_size && !size_ok_s;
  assign ready       = (state_r == ST_ARMED);
  assign beat_s      = ready && wreq_data;
  assign count_nxt_s = count_r + LANES_C;
  assign last_s      = beat_s && (count_nxt_s >= k_r);

  assign out_valid = out_valid_r;
  assign xk_out    = xk_r;
  assign zk_out    = zk_r;
  assign done      = done_r;
  assign err       = err_r;

  // Unrolled bit-serial recursion; lane 0 is the earliest bit of the beat.
  always_comb begin
    enc_x_s = {LANES{1'b0}};
    enc_z_s = {LANES{1'b0}};
    d1_s    = d_r[0];
    d2_s    = d_r[1];
    d3_s    = d_r[2];
    a_s     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      a_s        = data_in[i] ^ d2_s ^ d3_s;
      enc_x_s[i] = data_in[i];
      enc_z_s[i] = a_s ^ d1_s ^ d3_s;
      d3_s       = d2_s;
      d2_s       = d1_s;
      d1_s       = a_s;
    end
    enc_d_s = {d3_s, d2_s, d1_s};
  end

`ifdef RSC_TAIL_TERM_EN
  logic [1:0] tail_cnt_r;
  logic       tail_valid_r, tail_u_s, tail_z_s;
  logic [2:0] tail_d_s;

  // Termination input u=d2^d3 zeroes the feedback, so each cycle shifts a 0 into d1.
  assign tail_u_s   = d_r[1] ^ d_r[2];
  assign tail_z_s   = d_r[0] ^ d_r[2];
  assign tail_d_s   = {d_r[1], d_r[0], 1'b0};
  assign tail_valid = tail_valid_r;

  // Tail cycle counter and tail_valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tail_cnt_r   <= 2'd0;
      tail_valid_r <= 1'b0;
    end else begin
      tail_valid_r <= (state_r == ST_TAIL);
      tail_cnt_r   <= (state_r == ST_TAIL) ? tail_cnt_r + 2'd1 : 2'd0;
    end
  end
`else
  assign tail_valid = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (size_acc_s) state_nxt_s = ST_ARMED;
        else            state_nxt_s = ST_IDLE;
      end
      ST_ARMED: begin
`ifdef RSC_TAIL_TERM_EN
        if (last_s) state_nxt_s = ST_TAIL;
`else
        if (last_s) state_nxt_s = ST_DONE;
`endif
        else        state_nxt_s = ST_ARMED;
      end
`ifdef RSC_TAIL_TERM_EN
      ST_TAIL: begin
        if (tail_cnt_r == 2'd2) state_nxt_s = ST_DONE;
        else                    state_nxt_s = ST_TAIL;
      end
`endif
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, encoder memory, block counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      count_r     <= {CNT_W{1'b0}};
      k_r         <= {CNT_W{1'b0}};
      d_r         <= 3'b000;
      out_valid_r <= 1'b0;
      xk_r        <= {LANES{1'b0}};
      zk_r        <= {LANES{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= beat_s;
      done_r      <= (state_r == ST_DONE);
      err_r       <= size_bad_s;
      if (size_acc_s) begin
        k_r     <= size_ext_s;
        count_r <= {CNT_W{1'b0}};
        d_r     <= 3'b000;
      end else if (beat_s) begin
        count_r <= count_nxt_s;
        d_r     <= enc_d_s;
`ifdef RSC_TAIL_TERM_EN
      end else if (state_r == ST_TAIL) begin
        d_r     <= tail_d_s;
`endif
      end else begin
        d_r     <= d_r;
      end
      if (beat_s) begin
        xk_r <= enc_x_s;
        zk_r <= enc_z_s;
`ifdef RSC_TAIL_TERM_EN
      end else if (state_r == ST_TAIL) begin
        xk_r <= LANES'(tail_u_s);
        zk_r <= LANES'(tail_z_s);
`endif
      end else begin
        xk_r <= {LANES{1'b0}};
        zk_r <= {LANES{1'b0}};
      end
    end
  end
endmodule

// File: tb/tb_rsc_encoder_par.sv
// Self-checking bench for rsc_encoder_par (LANES=4) against a bit-serial reference encoder.
module tb_rsc_encoder_par;
  localparam int LANES = 4;
`ifdef RSC_TAIL_TERM_EN
  localparam int TAIL_N   = 3;
  localparam int TAIL_LAT = 4;
`else
  localparam int TAIL_N   = 0;
  localparam int TAIL_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset, wreq_size, wreq_data;
  logic [15:0] tb_size_in;
  logic [LANES-1:0] data_in;
  logic ready, out_valid, tail_valid, done, err;
  logic [LANES-1:0] xk_out, zk_out;

  rsc_encoder_par #(.LANES(LANES), .SIZE_W(16), .MAX_K(6144)) u_dut (
    .clk(clk), .reset(reset), .wreq_size(wreq_size), .tb_size_in(tb_size_in),
    .wreq_data(wreq_data), .data_in(data_in), .ready(ready), .out_valid(out_valid),
    .xk_out(xk_out), .zk_out(zk_out), .tail_valid(tail_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, ov_cnt = 0, last_ov_cyc = 0, done_cyc = 0;
  logic [7:0] obs_q[$], exp_q[$], ref_q[$];
  logic [1:0] obs_tail_q[$], exp_tail_q[$];
  logic [2:0] md = 3'b000;
  bit m_armed = 1'b0;
  int m_cnt = 0, m_k = 0;
  logic [3:0] arr[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (out_valid) begin
      obs_q.push_back({xk_out, zk_out});
      ov_cnt++;
      last_ov_cyc = cyc;
    end
    if (tail_valid) obs_tail_q.push_back({xk_out[0], zk_out[0]});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) err_cnt++;
  end

  task automatic write_size(input int k, input bit with_data);
    tb_size_in = k[15:0];
    wreq_size  = 1'b1;
    wreq_data  = with_data;
    data_in    = 4'($urandom);
    @(posedge clk); #1;
    wreq_size  = 1'b0;
    wreq_data  = 1'b0;
    if (!m_armed && k > 0 && k <= 6144 && (k % LANES) == 0) begin
      m_armed = 1'b1; md = 3'b000; m_cnt = 0; m_k = k;
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input bit v);
    bit acc;
    logic [3:0] x, z;
    logic a, u;
    acc = v && m_armed;
    wreq_data = v;
    data_in = d;
    @(posedge clk); #1;
    wreq_data = 1'b0;
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        a = d[i] ^ md[1] ^ md[2];
        x[i] = d[i];
        z[i] = a ^ md[0] ^ md[2];
        md = {md[1], md[0], a};
      end
      exp_q.push_back({x, z});
      m_cnt += LANES;
      if (m_cnt >= m_k) begin
        m_armed = 1'b0;
        for (int t = 0; t < TAIL_N; t++) begin
          u = md[1] ^ md[2];
          exp_tail_q.push_back({u, md[0] ^ md[2]});
          md = {md[1], md[0], 1'b0};
        end
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int n = 0; n < budget && done_cnt == start; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({ready, out_valid, xk_out, zk_out, tail_valid, done, err} !== 13'd0)
      begin $display("FAIL reset_outputs: got %b want 0", {ready, out_valid, xk_out, zk_out, tail_valid, done, err}); failures++; end
  endtask

  task automatic test_zero_block();
    int d0, mism;
    logic [7:0] e, o, acc_or;
    d0 = done_cnt;
    write_size(40, 1'b0);
    for (int i = 0; i < 10; i++) send_beat(4'h0, 1'b1);
    checks++;
    if (ready !== 1'b0) begin $display("FAIL zero_ready_after_last: got %b want 0", ready); failures++; end
    wait_done(30);
    checks++;
    if (done_cnt - d0 !== 1) begin $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); failures++; end
    checks++;
    if (done_cyc - last_ov_cyc !== TAIL_LAT) begin $display("FAIL zero_done_latency: got %0d want %0d", done_cyc - last_ov_cyc, TAIL_LAT); failures++; end
    mism = 0; acc_or = 8'h00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) mism++;
      else begin o = obs_q.pop_front(); acc_or |= o; if (o !== e) mism++; end
    end
    mism += obs_q.size(); obs_q.delete();
    while (obs_tail_q.size() > 0) acc_or[0] |= |obs_tail_q.pop_front();
    exp_tail_q.delete();
    checks++;
    if (mism !== 0) begin $display("FAIL zero_stream: got %0d bad beats want 0", mism); failures++; end
    checks++;
    if (acc_or !== 8'h00) begin $display("FAIL zero_all_bits: got %h want 00", acc_or); failures++; end
  endtask

  task automatic test_impulse();
    int mism;
    logic [7:0] e, o;
    logic [1:0] te;
    write_size(40, 1'b0);
    send_beat(4'b0001, 1'b1);
    for (int i = 0; i < 9; i++) send_beat(4'h0, 1'b1);
    wait_done(30);
    checks++;
    if (obs_q.size() < 2) begin $display("FAIL impulse_first_z: got %0d beats want >=2", obs_q.size()); failures++; end
    else if ({obs_q[1][0], obs_q[0][3:0]} !== 5'b01111)
      begin $display("FAIL impulse_first_z: got %b want 01111", {obs_q[1][0], obs_q[0][3:0]}); failures++; end
    mism = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) mism++;
      else begin o = obs_q.pop_front(); if (o !== e) mism++; end
    end
    mism += obs_q.size(); obs_q.delete();
    while (exp_tail_q.size() > 0) begin
      te = exp_tail_q.pop_front();
      if (obs_tail_q.size() == 0) mism++;
      else if (obs_tail_q.pop_front() !== te) mism++;
    end
    mism += obs_tail_q.size(); obs_tail_q.delete();
    checks++;
    if (mism !== 0) begin $display("FAIL impulse_stream: got %0d bad beats want 0", mism); failures++; end
  endtask

  task automatic test_random_block();
    int mism, d0;
    logic [7:0] e, o;
    logic [1:0] te;
    d0 = done_cnt;
    write_size(40, 1'b0);
    for (int i = 0; i < 10; i++) send_beat(4'($urandom), 1'b1);
    wait_done(30);
    mism = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) mism++;
      else begin o = obs_q.pop_front(); if (o !== e) mism++; end
    end
    mism += obs_q.size(); obs_q.delete();
    while (exp_tail_q.size() > 0) begin
      te = exp_tail_q.pop_front();
      if (obs_tail_q.size() == 0) mism++;
      else if (obs_tail_q.pop_front() !== te) mism++;
    end
    mism += obs_tail_q.size(); obs_tail_q.delete();
    checks++;
    if (mism !== 0) begin $display("FAIL random_stream: got %0d bad beats want 0", mism); failures++; end
    checks++;
    if (done_cnt - d0 !== 1) begin $display("FAIL random_done_count: got %0d want 1", done_cnt - d0); failures++; end
  endtask

  task automatic test_sizes();
    int e0, mism;
    int bad[3] = '{6, 0, 6148};
    logic [7:0] e, o;
    for (int i = 0; i < 3; i++) begin
      e0 = err_cnt;
      write_size(bad[i], 1'b0);
      @(posedge clk); #1;
      checks++;
      if (err_cnt - e0 !== 1 || ready !== 1'b0)
        begin $display("FAIL size_%0d_err: got err=%0d ready=%b want err=1 ready=0", bad[i], err_cnt - e0, ready); failures++; end
    end
    e0 = err_cnt;
    write_size(8, 1'b1);
    checks++;
    if (ready !== 1'b1) begin $display("FAIL size_8_accept: got ready=%b want 1", ready); failures++; end
    write_size(4, 1'b0);
    write_size(6, 1'b0);
    send_beat(4'($urandom), 1'b1);
    checks++;
    if (ready !== 1'b1) begin $display("FAIL size_ignored_armed: got ready=%b want 1", ready); failures++; end
    send_beat(4'($urandom), 1'b1);
    wait_done(30);
    checks++;
    if (err_cnt - e0 !== 0) begin $display("FAIL size_no_err: got %0d want 0", err_cnt - e0); failures++; end
    mism = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) mism++;
      else begin o = obs_q.pop_front(); if (o !== e) mism++; end
    end
    mism += obs_q.size(); obs_q.delete();
    exp_tail_q.delete(); obs_tail_q.delete();
    checks++;
    if (mism !== 0) begin $display("FAIL size_8_stream: got %0d bad beats want 0", mism); failures++; end
  endtask

  task automatic test_gapped();
    int mism, mref, ov0;
    logic [7:0] e, o;
    for (int i = 0; i < 4; i++) arr[i] = 4'($urandom);
    write_size(16, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(arr[i], 1'b1);
    wait_done(30);
    ref_q = obs_q;
    obs_q.delete(); exp_q.delete(); exp_tail_q.delete(); obs_tail_q.delete();
    ov0 = ov_cnt;
    write_size(16, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_beat(arr[i], 1'b1);
      send_beat(4'($urandom), 1'b0);
    end
    wait_done(30);
    checks++;
    if (ov_cnt - ov0 !== 4) begin $display("FAIL gap_out_valid: got %0d valid cycles want 4", ov_cnt - ov0); failures++; end
    mism = 0; mref = 0;
    for (int i = 0; i < 4; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      if (obs_q.size() == 0) begin mism++; mref++; end
      else begin
        o = obs_q.pop_front();
        if (o !== e) mism++;
        if (i >= ref_q.size() || o !== ref_q[i]) mref++;
      end
    end
    mism += obs_q.size() + exp_q.size(); obs_q.delete(); exp_q.delete();
    exp_tail_q.delete(); obs_tail_q.delete();
    checks++;
    if (mism !== 0) begin $display("FAIL gap_stream: got %0d bad beats want 0", mism); failures++; end
    checks++;
    if (mref !== 0) begin $display("FAIL gap_vs_ungapped: got %0d bad beats want 0", mref); failures++; end
  endtask

  task automatic test_reset_mid();
    int d0, mref;
    d0 = done_cnt;
    write_size(80, 1'b0);
    for (int i = 0; i < 10; i++) send_beat(4'($urandom), 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_armed = 1'b0; md = 3'b000;
    checks++;
    if ({ready, out_valid, xk_out, zk_out, tail_valid, done, err} !== 13'd0)
      begin $display("FAIL midreset_outputs: got %b want 0", {ready, out_valid, xk_out, zk_out, tail_valid, done, err}); failures++; end
    repeat (8) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt - d0 !== 0) begin $display("FAIL midreset_no_done: got %0d want 0", done_cnt - d0); failures++; end
    obs_q.delete(); exp_q.delete(); exp_tail_q.delete(); obs_tail_q.delete();
    write_size(16, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(arr[i], 1'b1);
    wait_done(30);
    mref = 0;
    for (int i = 0; i < 4; i++) begin
      if (obs_q.size() == 0 || i >= ref_q.size()) mref++;
      else if (obs_q.pop_front() !== ref_q[i]) mref++;
    end
    mref += obs_q.size(); obs_q.delete(); exp_q.delete();
    checks++;
    if (mref !== 0) begin $display("FAIL midreset_fresh_block: got %0d bad beats want 0", mref); failures++; end
    checks++;
    if (done_cnt - d0 !== 1) begin $display("FAIL midreset_fresh_done: got %0d want 1", done_cnt - d0); failures++; end
  endtask

  initial begin
    reset = 1'b1; wreq_size = 1'b0; wreq_data = 1'b0; tb_size_in = 16'd0; data_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_zero_block();
    test_impulse();
    test_random_block();
    test_sizes();
    test_gapped();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
